// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one interval counter between NREQ requesters.
// The granted requester's max is latched, the counter runs 0..max, then done pulses.
module counter_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   req_max,
    input  logic                pause,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [N-1:0]        count,
    output logic [NREQ-1:0]     done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N-1:0]    ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] ONE_NREQ  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   LAST_INIT = IW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [N-1:0]    max_q,   max_d;
    logic [N-1:0]    count_q, count_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q,  busy_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic            found_s;
    logic [IW-1:0]   sel_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = ONE_NREQ << idx;
    endfunction

    // Next-state logic: arbitration, interval counting, cancel handling.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        max_d   = max_q;
        count_d = count_q;
        found_s = 1'b0;
        sel_s   = '0;
        case (state_q)
            S_IDLE: begin
                // Search starts just after the last owner, so it ends up lowest priority.
                for (int k = 1; k <= NREQ; k++) begin
                    sel_s = IW'((int'(last_q) + k) % NREQ);
                    if (!found_s && req[sel_s]) begin
                        found_s = 1'b1;
                        owner_d = sel_s;
                        max_d   = req_max[sel_s*N +: N];
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                count_d = '0;
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                    count_d = '0;
                end else if (!pause && (count_q == max_q)) begin
                    state_d = S_DONE;
                end else if (!pause) begin
                    count_d = count_q + ONE_N;
                end else begin
                    count_d = count_q;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave registers.
        if ((state_d == S_LOAD) || (state_d == S_RUN)) begin
            grant_d = onehot(owner_d);
            busy_d  = 1'b1;
        end else begin
            grant_d = '0;
            busy_d  = 1'b0;
        end
        if (state_d == S_DONE) begin
            done_d = onehot(owner_d);
        end else begin
            done_d = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= LAST_INIT;
            max_q   <= '0;
            count_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            max_q   <= max_d;
            count_q <= count_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: stimulus pushes expected grant/done events
// into a queue; a monitor pops and compares them as the DUT presents them.
module tb_counter_arbiter;

    logic        clk;
    logic        nrst;
    logic [3:0]  req;
    logic [31:0] req_max;
    logic        pause;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  count;
    logic [3:0]  done;

    typedef struct packed {
        logic       is_done;
        logic [3:0] vec;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  tests;
    int  fails;
    logic [3:0] prev_grant;

    counter_arbiter #(.NREQ(4), .N(8)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .req     (req),
        .req_max (req_max),
        .pause   (pause),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic d, input logic [3:0] v, input logic [7:0] c);
        ev_t e;
        e.is_done = d;
        e.vec     = v;
        e.cnt     = c;
        exp_q.push_back(e);
    endtask

    task automatic set_max(input int i, input logic [7:0] m);
        req_max[i*8 +: 8] = m;
    endtask

    // Wait (bounded) for a done pulse; drop that requester's req on seeing it.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done == 4'b0000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done == 4'b0000) chk({nm, "_timeout"}, 0, 1);
        req = req & ~done;
    endtask

    // Monitor: every new grant and every done pulse consumes one expected event.
    initial begin
        ev_t e;
        prev_grant = 4'b0000;
        forever begin
            @(negedge clk);
            if (grant != 4'b0000 && grant != prev_grant) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_grant", int'(grant), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_kind_grant", int'(e.is_done), 0);
                    chk("mon_grant", int'(grant), int'(e.vec));
                    chk("mon_grant_count0", int'(count), 0);
                end
            end
            if (done != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_done", int'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_kind_done", int'(e.is_done), 1);
                    chk("mon_done", int'(done), int'(e.vec));
                    chk("mon_done_count", int'(count), int'(e.cnt));
                    chk("mon_done_grant0", int'(grant), 0);
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        int seq3 [9];
        int gcnt;
        tests   = 0;
        fails   = 0;
        nrst    = 1'b0;
        req     = 4'b0000;
        req_max = 32'h0000_0000;
        pause   = 1'b0;
        seq3 = '{0, 1, 2, 2, 2, 2, 3, 4, 5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done), 0);

        // Single request, max=3
        nrst = 1'b1;
        set_max(0, 8'd3);
        req = 4'b0001;
        push(1'b0, 4'b0001, 8'd0);
        push(1'b1, 4'b0001, 8'd3);
        @(negedge clk);
        chk("t1_load_grant", int'(grant), 1);
        chk("t1_load_busy", int'(busy), 1);
        chk("t1_load_count", int'(count), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_run_count", int'(count), i);
            chk("t1_run_grant", int'(grant), 1);
        end
        @(negedge clk);
        chk("t1_done", int'(done), 1);
        chk("t1_done_grant", int'(grant), 0);
        chk("t1_done_busy", int'(busy), 0);
        chk("t1_done_count", int'(count), 3);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_done", int'(done), 0);

        // All four request, max=1 each; round robin from a fresh pointer
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_max(i, 8'd1);
            push(1'b0, 4'(1 << i), 8'd0);
            push(1'b1, 4'(1 << i), 8'd1);
        end
        req = 4'b1111;
        for (int o = 0; o < 4; o++) begin
            gcnt = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (grant == 4'(1 << o)) gcnt++;
                if (done != 4'b0000) break;
            end
            chk("t2_done_owner", int'(done), 1 << o);
            chk("t2_grant_cycles", gcnt, 3);
            req = req & ~done;
        end
        @(negedge clk);

        // Owner 2, max=5, paused 3 cycles at count 2
        set_max(2, 8'd5);
        req = 4'b0100;
        push(1'b0, 4'b0100, 8'd0);
        push(1'b1, 4'b0100, 8'd5);
        @(negedge clk);
        chk("t3_load_grant", int'(grant), 4);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t3_count", int'(count), seq3[i]);
            if (i == 2) pause = 1'b1;
            if (i == 5) pause = 1'b0;
        end
        @(negedge clk);
        chk("t3_done", int'(done), 4);
        req = 4'b0000;
        @(negedge clk);

        // Cancel of owner 1 at count 4; pending req[2] granted next
        set_max(1, 8'd10);
        set_max(2, 8'd2);
        req = 4'b0110;
        push(1'b0, 4'b0010, 8'd0);
        push(1'b0, 4'b0100, 8'd0);
        push(1'b1, 4'b0100, 8'd2);
        @(negedge clk);
        chk("t4_load_grant", int'(grant), 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_count", int'(count), i);
        end
        req = 4'b0100;
        @(negedge clk);
        chk("t4_cancel_grant", int'(grant), 0);
        chk("t4_cancel_busy", int'(busy), 0);
        chk("t4_cancel_count", int'(count), 0);
        chk("t4_cancel_done", int'(done), 0);
        @(negedge clk);
        chk("t4_next_grant", int'(grant), 4);
        wait_done("t4");
        @(negedge clk);

        // max=0 on requester 3: one RUN cycle
        set_max(3, 8'd0);
        req = 4'b1000;
        push(1'b0, 4'b1000, 8'd0);
        push(1'b1, 4'b1000, 8'd0);
        @(negedge clk);
        chk("t5_load_grant", int'(grant), 8);
        @(negedge clk);
        chk("t5_run_busy", int'(busy), 1);
        chk("t5_run_count", int'(count), 0);
        @(negedge clk);
        chk("t5_done", int'(done), 8);
        req = 4'b0000;
        @(negedge clk);

        // Reset mid-RUN at count 7, then pointer restarts at requester 0
        set_max(0, 8'd20);
        req = 4'b0001;
        push(1'b0, 4'b0001, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("t6_pre_count", int'(count), 7);
        nrst = 1'b0;
        req = 4'b1001;
        set_max(0, 8'd1);
        set_max(3, 8'd2);
        @(negedge clk);
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_done", int'(done), 0);
        push(1'b0, 4'b0001, 8'd0);
        push(1'b1, 4'b0001, 8'd1);
        push(1'b0, 4'b1000, 8'd0);
        push(1'b1, 4'b1000, 8'd2);
        nrst = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", int'(grant), 1);
        wait_done("t6a");
        @(negedge clk);
        wait_done("t6b");
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
